// File: rtl/lru8_set_ctrl.sv
// lru8_set_ctrl: per-set 8-way true-LRU rank store with hit/fill arbitration and init sweep; define LRU8_BYPASS_EN to forward S1 results for same-set back-to-back grants
module lru8_set_ctrl #(
    parameter int WAYS_LOG = 3,
    parameter int SETS_LOG = 5
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_flush,
    output logic                o_ready,
    input  logic                i_hit_req,
    input  logic [SETS_LOG-1:0] i_hit_set,
    input  logic [WAYS_LOG-1:0] i_hit_way,
    output logic                o_hit_gnt,
    input  logic                i_fill_req,
    input  logic [SETS_LOG-1:0] i_fill_set,
    output logic                o_fill_gnt,
    output logic                o_vic_vld,
    output logic [WAYS_LOG-1:0] o_vic_way
);
    localparam int WAYS = 1 << WAYS_LOG;
    localparam int SETS = 1 << SETS_LOG;
    localparam int VW   = WAYS * WAYS_LOG;

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    typedef enum logic {PRIO_FILL, PRIO_HIT} prio_t;

    state_t              r_state, w_state_nxt;
    logic [SETS_LOG-1:0] r_ptr, w_ptr_nxt;
    prio_t               r_prio;
    logic [VW-1:0]       r_mem [SETS];
    logic                r_s1_vld;
    logic [SETS_LOG-1:0] r_s1_set;
    logic [WAYS_LOG-1:0] r_s1_way;
    logic [VW-1:0]       r_s1_vec;
    logic                r_vic_vld;
    logic [WAYS_LOG-1:0] r_vic_way;
    logic                w_run, w_hit_blk, w_fill_blk, w_fill_wins, w_hit_gnt, w_fill_gnt;
    logic [SETS_LOG-1:0] w_sel_set;
    logic [VW-1:0]       w_rd_vec, w_s1_new, w_init_vec;
    logic [WAYS_LOG-1:0] w_vic, w_s1_old;

    assign o_ready    = (r_state == ST_RUN);
    assign o_hit_gnt  = w_hit_gnt;
    assign o_fill_gnt = w_fill_gnt;
    assign o_vic_vld  = r_vic_vld;
    assign o_vic_way  = r_vic_way;

    // sweep pattern: way w gets rank w
    always_comb begin
        w_init_vec = '0;
        for (int w = 0; w < WAYS; w++) w_init_vec[w*WAYS_LOG +: WAYS_LOG] = WAYS_LOG'(w);
    end

    // state register and sweep pointer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_INIT;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // next state: flush restarts the sweep from set 0, sweep ends after the last set
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        if (i_flush) begin
            w_state_nxt = ST_INIT;
            w_ptr_nxt   = '0;
        end else if (r_state == ST_INIT) begin
            w_ptr_nxt = r_ptr + 1'b1;
            if (r_ptr == SETS_LOG'(SETS - 1)) w_state_nxt = ST_RUN;
        end
    end

    assign w_run = (r_state == ST_RUN) && !i_flush;
`ifdef LRU8_BYPASS_EN
    assign w_hit_blk  = 1'b0;
    assign w_fill_blk = 1'b0;
`else
    assign w_hit_blk  = r_s1_vld && (r_s1_set == i_hit_set);
    assign w_fill_blk = r_s1_vld && (r_s1_set == i_fill_set);
`endif
    // a stalled winner hands the slot to the other requester without moving prio
    assign w_fill_wins = i_fill_req && (!i_hit_req || r_prio == PRIO_FILL);
    assign w_hit_gnt   = w_run && i_hit_req && !w_hit_blk && (!w_fill_wins || w_fill_blk);
    assign w_fill_gnt  = w_run && i_fill_req && !w_fill_blk && (w_fill_wins || w_hit_blk);
    assign w_sel_set   = w_fill_gnt ? i_fill_set : i_hit_set;

    // S0 read, taking the S1 result when it targets the same set
    always_comb begin
        w_rd_vec = r_mem[w_sel_set];
`ifdef LRU8_BYPASS_EN
        if (r_s1_vld && r_s1_set == w_sel_set) w_rd_vec = w_s1_new;
`endif
    end

    // victim is the way currently holding the LRU rank
    always_comb begin
        w_vic = '0;
        for (int w = 0; w < WAYS; w++)
            if (w_rd_vec[w*WAYS_LOG +: WAYS_LOG] == WAYS_LOG'(WAYS - 1)) w_vic = WAYS_LOG'(w);
    end

    assign w_s1_old = r_s1_vec[r_s1_way*WAYS_LOG +: WAYS_LOG];

    // S1 update: target becomes MRU, ways more recent than it age by one
    always_comb begin
        w_s1_new = r_s1_vec;
        for (int w = 0; w < WAYS; w++) begin
            if (WAYS_LOG'(w) == r_s1_way) w_s1_new[w*WAYS_LOG +: WAYS_LOG] = '0;
            else if (r_s1_vec[w*WAYS_LOG +: WAYS_LOG] < w_s1_old)
                w_s1_new[w*WAYS_LOG +: WAYS_LOG] = r_s1_vec[w*WAYS_LOG +: WAYS_LOG] + 1'b1;
        end
    end

    // arbitration priority, S1 pipeline register and victim return
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_prio    <= PRIO_FILL;
            r_s1_vld  <= 1'b0;
            r_s1_set  <= '0;
            r_s1_way  <= '0;
            r_s1_vec  <= '0;
            r_vic_vld <= 1'b0;
            r_vic_way <= '0;
        end else begin
            if (i_hit_req && i_fill_req && (w_fill_wins ? w_fill_gnt : w_hit_gnt))
                r_prio <= w_fill_wins ? PRIO_HIT : PRIO_FILL;
            r_s1_vld <= w_hit_gnt || w_fill_gnt;
            if (w_hit_gnt || w_fill_gnt) begin
                r_s1_set <= w_sel_set;
                r_s1_way <= w_fill_gnt ? w_vic : i_hit_way;
                r_s1_vec <= w_rd_vec;
            end
            r_vic_vld <= w_fill_gnt;
            if (w_fill_gnt) r_vic_way <= w_vic;
        end
    end

    // rank storage: sweep writes and S1 write-backs never coincide
    always_ff @(posedge i_clk) begin
        if (r_state == ST_INIT) r_mem[r_ptr] <= w_init_vec;
        else if (r_s1_vld) r_mem[r_s1_set] <= w_s1_new;
    end
endmodule

// File: tb/tb_lru8_set_ctrl.sv
// tb_lru8_set_ctrl: directed and randomized checks of lru8_set_ctrl against a recency-list model
module tb_lru8_set_ctrl;
    logic       clk = 0, rst_n = 0, flush = 0, hit_req = 0, fill_req = 0;
    logic [4:0] hit_set = 0, fill_set = 0;
    logic [2:0] hit_way = 0;
    logic       ready, hit_gnt, fill_gnt, vic_vld;
    logic [2:0] vic_way;
    int         tests = 0, fails = 0;
`ifdef LRU8_BYPASS_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif

    always #5 clk = ~clk;

    lru8_set_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush), .o_ready(ready),
        .i_hit_req(hit_req), .i_hit_set(hit_set), .i_hit_way(hit_way), .o_hit_gnt(hit_gnt),
        .i_fill_req(fill_req), .i_fill_set(fill_set), .o_fill_gnt(fill_gnt),
        .o_vic_vld(vic_vld), .o_vic_way(vic_way)
    );

    // order[s][i] is the way at recency position i of set s (0 = most recent)
    int order [32][8];
    bit m_init = 1, m_prio_fill = 1, m_vic_pend = 0, m_s1_vld = 0, gh = 0, gf = 0;
    int m_ptr = 0, m_vic_way = 0, m_s1_set = 0;
    int cyc = 0, vic_cnt = 0, last_vic = -1, gnt_cnt = 0, h_cyc = 0;
    int gq[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void touch(input int s, input int w);
        int p = 0;
        for (int i = 0; i < 8; i++) if (order[s][i] == w) p = i;
        for (int i = p; i > 0; i--) order[s][i] = order[s][i-1];
        order[s][0] = w;
    endfunction

    function automatic logic [23:0] model_vec(input int s);
        logic [23:0] v = '0;
        for (int i = 0; i < 8; i++) v[order[s][i]*3 +: 3] = 3'(i);
        return v;
    endfunction

    function automatic logic [23:0] pack8(input int r0, r1, r2, r3, r4, r5, r6, r7);
        int r[8] = '{r0, r1, r2, r3, r4, r5, r6, r7};
        logic [23:0] v = '0;
        for (int w = 0; w < 8; w++) v[w*3 +: 3] = 3'(r[w]);
        return v;
    endfunction

    function automatic bit blocked(input logic [4:0] s);
`ifdef LRU8_BYPASS_EN
        return s === 5'bx;
`else
        return m_s1_vld && m_s1_set == int'(s);
`endif
    endfunction

    always @(negedge clk) begin : cmp
        bit eh, ef, hb, fb;
        if (!rst_n) begin
            m_init = 1; m_ptr = 0; m_prio_fill = 1; m_vic_pend = 0; m_s1_vld = 0; gh = 0; gf = 0;
        end else begin
            cyc++;
            eh = 0; ef = 0;
            hb = blocked(hit_set);
            fb = blocked(fill_set);
            if (!m_init && !flush) begin
                if (hit_req && fill_req) begin
                    if (m_prio_fill ? !fb : !hb) begin
                        ef = m_prio_fill; eh = !m_prio_fill; m_prio_fill = !m_prio_fill;
                    end else begin
                        ef = !m_prio_fill && !fb; eh = m_prio_fill && !hb;
                    end
                end else begin
                    eh = hit_req && !hb; ef = fill_req && !fb;
                end
            end
            chk("ready", ready, 32'(!m_init));
            chk("hit_gnt", hit_gnt, 32'(eh));
            chk("fill_gnt", fill_gnt, 32'(ef));
            chk("vic_vld", vic_vld, 32'(m_vic_pend));
            if (m_vic_pend) chk("vic_way", vic_way, m_vic_way);
            if (vic_vld) begin vic_cnt++; last_vic = vic_way; end
            if (hit_gnt || fill_gnt) gnt_cnt++;
            gh = eh; gf = ef;
            if (eh) begin gq.push_back(0); h_cyc = cyc; end
            if (ef) gq.push_back(1);
            m_vic_pend = ef;
            if (ef) begin m_vic_way = order[fill_set][7]; touch(fill_set, m_vic_way); end
            if (eh) touch(hit_set, hit_way);
            m_s1_vld = eh || ef;
            m_s1_set = ef ? fill_set : hit_set;
            if (flush) begin
                m_init = 1; m_ptr = 0;
            end else if (m_init) begin
                for (int i = 0; i < 8; i++) order[m_ptr][i] = i;
                if (m_ptr == 31) m_init = 0;
                m_ptr = (m_ptr + 1) % 32;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_hit(input int s, input int w);
        int n = 0;
        hit_req = 1; hit_set = 5'(s); hit_way = 3'(w);
        do begin tick(); n++; end while (!gh && n < 200);
        chk("hit_wait", 32'(gh), 1);
        hit_req = 0;
    endtask

    task automatic do_fill(input int s);
        int n = 0;
        fill_req = 1; fill_set = 5'(s);
        do begin tick(); n++; end while (!gf && n < 200);
        chk("fill_wait", 32'(gf), 1);
        fill_req = 0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin tick(); n++; end while (!ready && n < 200);
    endtask

    task automatic check_all(input string nm);
        for (int s = 0; s < 32; s++) chk(nm, 32'(dut.r_mem[s]), 32'(model_vec(s)));
    endtask

    initial begin
        int n, c1, vc0, gc0;
        for (int s = 0; s < 32; s++) for (int i = 0; i < 8; i++) order[s][i] = 7 - i;
        repeat (3) tick();
        rst_n = 1;
        wait_ready(n);
        chk("t1_ready_latency", n, 32);
        tick(); tick();
        for (int s = 0; s < 32; s++) chk("t1_init_rank", 32'(dut.r_mem[s]), 32'(pack8(0, 1, 2, 3, 4, 5, 6, 7)));
        chk("t1_model_init", 32'(model_vec(17)), 32'(pack8(0, 1, 2, 3, 4, 5, 6, 7)));

        do_hit(3, 5);
        tick(); tick();
        chk("t2_hit_rank", 32'(dut.r_mem[3]), 32'(pack8(1, 2, 3, 4, 5, 0, 6, 7)));
        chk("t2_hit_model", 32'(model_vec(3)), 32'(pack8(1, 2, 3, 4, 5, 0, 6, 7)));
        vc0 = vic_cnt;
        do_fill(3);
        tick();
        chk("t2_vic_pulse", vic_cnt, vc0 + 1);
        chk("t2_vic_way", last_vic, 7);
        tick();
        chk("t2_fill_rank", 32'(dut.r_mem[3]), 32'(pack8(2, 3, 4, 5, 6, 1, 7, 0)));
        chk("t2_fill_model", 32'(model_vec(3)), 32'(pack8(2, 3, 4, 5, 6, 1, 7, 0)));

        gq.delete();
        rst_n = 0; hit_req = 1; hit_set = 1; hit_way = 4; fill_req = 1; fill_set = 2;
        tick();
        rst_n = 1;
        n = 0;
        while (gq.size() < 6 && n < 200) begin tick(); n++; end
        hit_req = 0; fill_req = 0;
        chk("t3_grant_count", 32'(gq.size() >= 6), 1);
        chk("t3_grant0_fill", gq[0], 1);
        chk("t3_grant1_hit", gq[1], 0);
        chk("t3_grant2_fill", gq[2], 1);
        chk("t3_grant3_hit", gq[3], 0);
        tick(); tick();

        do_hit(9, 2);
        c1 = h_cyc;
        do_hit(9, 6);
        chk("t4_grant_gap", h_cyc - c1, GAP);
        tick(); tick();
        chk("t4_rank", 32'(dut.r_mem[9]), 32'(pack8(2, 3, 1, 4, 5, 6, 0, 7)));

        vc0 = vic_cnt;
        do_fill(4);
        flush = 1; hit_req = 1; hit_set = 5; hit_way = 1; fill_req = 1; fill_set = 6;
        gc0 = gnt_cnt;
        tick();
        flush = 0;
        chk("t5_vic_pulse", vic_cnt, vc0 + 1);
        chk("t5_ready_drop", 32'(ready), 0);
        repeat (32) tick();
        hit_req = 0; fill_req = 0;
        chk("t5_no_grants", gnt_cnt, gc0);
        chk("t5_ready_back", 32'(ready), 1);
        tick(); tick();
        for (int s = 0; s < 32; s++) chk("t5_reinit_rank", 32'(dut.r_mem[s]), 32'(pack8(0, 1, 2, 3, 4, 5, 6, 7)));

        flush = 1;
        tick();
        flush = 0;
        repeat (17) tick();
        #2 rst_n = 0;
        #1;
        chk("t6_ready", 32'(ready), 0);
        chk("t6_hit_gnt", 32'(hit_gnt), 0);
        chk("t6_fill_gnt", 32'(fill_gnt), 0);
        chk("t6_vic_vld", 32'(vic_vld), 0);
        chk("t6_vic_way", 32'(vic_way), 0);
        tick(); tick();
        rst_n = 1;
        wait_ready(n);
        chk("t6_ready_latency", n, 32);

        for (int k = 0; k < 3000; k++) begin
            tick();
            flush = 0;
            if (hit_req && gh) hit_req = 0;
            if (fill_req && gf) fill_req = 0;
            if (!hit_req && $urandom_range(0, 2) != 0) begin
                hit_req = 1; hit_set = 5'($urandom_range(0, 7)); hit_way = 3'($urandom);
            end
            if (!fill_req && $urandom_range(0, 2) == 0) begin
                fill_req = 1; fill_set = 5'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 499) == 0) flush = 1;
        end
        tick();
        hit_req = 0; fill_req = 0; flush = 0;
        if (!ready) wait_ready(n);
        tick(); tick(); tick();
        check_all("final_rank");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
